// File: rtl/instr_byte_fetch_if.sv
// Fetch-unit bus bundle: byte-wide instruction memory port, decode-side
// valid/ready handshake, redirect request and NOP-halt status.
interface instr_byte_fetch_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_en;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic [2:0]        nop_count;

  modport master (
    output mem_addr, mem_rd_en, instr, instr_pc, instr_valid, halt, nop_count,
    input  mem_rdata, instr_ready, redirect_en, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_rd_en, instr, instr_pc, instr_valid, halt, nop_count,
    output mem_rdata, instr_ready, redirect_en, redirect_pc
  );
endinterface

// File: rtl/instr_byte_fetch.sv
// Big-endian byte-serial instruction fetch with valid/ready output and redirect.
// Optional NOP-run halt is built only when IFETCH_NOP_HALT_EN is defined.
module instr_byte_fetch #(
  parameter int          ADDR_W         = 8,
  parameter int          NOP_HALT_COUNT = 4,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_byte_fetch_if.master   bus
);

  if (NOP_HALT_COUNT < 1 || NOP_HALT_COUNT > 7) begin : g_bad_cfg
    $error("NOP_HALT_COUNT must be in 1..7");
  end

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD
`ifdef IFETCH_NOP_HALT_EN
    , HALTED
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [1:0]  k_q;
  logic        rd_pend_q;
  logic [1:0]  rd_idx_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        hs;

`ifdef IFETCH_NOP_HALT_EN
  logic [2:0]  nop_q;
  logic [2:0]  nop_next;
  logic        halt_hit;

  always_comb begin
    nop_next = 3'd0;
    if (instr_q == 32'd0) nop_next = (nop_q == 3'd7) ? 3'd7 : nop_q + 3'd1;
  end
  assign halt_hit = (nop_next == 3'(NOP_HALT_COUNT));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every variable assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    hs      = 1'b0;
    case (state_q)
      FETCH: if (k_q == 2'd3) state_d = DRAIN;
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (bus.instr_ready) begin
          hs      = 1'b1;
          state_d = FETCH;
`ifdef IFETCH_NOP_HALT_EN
          if (halt_hit) state_d = HALTED;
`endif
        end
      end
`ifdef IFETCH_NOP_HALT_EN
      HALTED: state_d = HALTED;
`endif
      default: state_d = FETCH;
    endcase
    if (bus.redirect_en) state_d = FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      k_q        <= 2'd0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= 2'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
`ifdef IFETCH_NOP_HALT_EN
      nop_q      <= 3'd0;
`endif
    end else if (bus.redirect_en) begin
      // Redirect wins over everything, including a same-cycle handshake;
      // the byte still in flight is dropped by clearing rd_pend_q.
      pc_q      <= bus.redirect_pc & ~32'd3;
      k_q       <= 2'd0;
      rd_pend_q <= 1'b0;
`ifdef IFETCH_NOP_HALT_EN
      nop_q     <= 3'd0;
`endif
    end else begin
      rd_pend_q <= (state_q == FETCH);
      rd_idx_q  <= k_q;
      if (state_q == FETCH) k_q <= k_q + 2'd1;
      if (rd_pend_q) begin
        case (rd_idx_q)
          2'd0:    instr_q[31:24] <= bus.mem_rdata;
          2'd1:    instr_q[23:16] <= bus.mem_rdata;
          2'd2:    instr_q[15:8]  <= bus.mem_rdata;
          default: instr_q[7:0]   <= bus.mem_rdata;
        endcase
      end
      if (state_q == DRAIN) instr_pc_q <= pc_q;
      if (hs) begin
        pc_q  <= pc_q + 32'd4;
`ifdef IFETCH_NOP_HALT_EN
        nop_q <= nop_next;
`endif
      end
    end
  end

  // Reads are issued combinationally so the first byte request goes out in the
  // cycle after reset releases; reset forces the strobe and address low.
  assign bus.mem_rd_en   = (state_q == FETCH) && !reset;
  assign bus.mem_addr    = reset ? '0 : pc_q[ADDR_W-1:0] + ADDR_W'(k_q);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = (state_q == HOLD);

`ifdef IFETCH_NOP_HALT_EN
  assign bus.halt      = (state_q == HALTED);
  assign bus.nop_count = nop_q;
`else
  assign bus.halt      = 1'b0;
  assign bus.nop_count = 3'd0;
`endif

endmodule

// File: tb/tb_instr_byte_fetch.sv
// Directed bench for instr_byte_fetch: byte memory model plus step-by-step
// checks of latency, backpressure, NOP halt, redirect, address wrap and reset.
module tb_instr_byte_fetch;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] mem [256];

  instr_byte_fetch_if #(.ADDR_W(8)) bus ();

  instr_byte_fetch #(
    .ADDR_W(8),
    .NOP_HALT_COUNT(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("valid_timeout", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = target;
    tick();
    bus.redirect_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}         = 32'h200a000a;
    {mem[4], mem[5], mem[6], mem[7]}         = 32'h200c000b;
    {mem[24], mem[25], mem[26], mem[27]}     = 32'h11223344;
    {mem[28], mem[29], mem[30], mem[31]}     = 32'h55667788;
    {mem[52], mem[53], mem[54], mem[55]}     = 32'h8d500000;
    {mem[252], mem[253], mem[254], mem[255]} = 32'haabbccdd;

    reset           = 1'b1;
    bus.mem_rdata   = 8'h00;
    bus.instr_ready = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    tick();
    check("rst_rd_en",   32'(bus.mem_rd_en),   32'd0);
    check("rst_addr",    32'(bus.mem_addr),    32'd0);
    check("rst_valid",   32'(bus.instr_valid), 32'd0);
    check("rst_instr",   bus.instr,            32'd0);
    check("rst_halt",    32'(bus.halt),        32'd0);
    check("rst_nop",     32'(bus.nop_count),   32'd0);

    // First word: four byte reads then valid on the 5th edge.
    reset = 1'b0;
    #1;
    check("w0_rd0", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h100);
    tick();
    check("w0_rd1", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h101);
    tick();
    check("w0_rd2", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h102);
    tick();
    check("w0_rd3", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h103);
    tick();
    check("w0_drain_rd", 32'(bus.mem_rd_en),   32'd0);
    check("w0_drain_v",  32'(bus.instr_valid), 32'd0);
    tick();
    check("w0_valid", 32'(bus.instr_valid), 32'd1);
    check("w0_instr", bus.instr,            32'h200a000a);
    check("w0_pc",    bus.instr_pc,         32'h0);
    tick();
    check("w0_taken", 32'(bus.instr_valid), 32'd0);
    check("w1_rd0", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h104);

    // Backpressure on the word at 4.
    bus.instr_ready = 1'b0;
    wait_valid();
    for (int c = 0; c < 3; c++) begin
      check("bp_instr", bus.instr,            32'h200c000b);
      check("bp_pc",    bus.instr_pc,         32'h4);
      check("bp_rd_en", 32'(bus.mem_rd_en),   32'd0);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      if (c < 2) tick();
    end
    tick();
    check("bp_stall4", 32'(bus.instr_valid), 32'd1);
    bus.instr_ready = 1'b1;
    tick();
    check("bp_taken", 32'(bus.instr_valid), 32'd0);
    check("bp_next",  {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h108);
    check("bp_nop",   32'(bus.nop_count), 32'd0);

    // Four zero words at 8..20.
    for (int i = 1; i <= 4; i++) begin
      wait_valid();
      check("nop_instr", bus.instr,    32'h0);
      check("nop_pc",    bus.instr_pc, 32'(4 + 4 * i));
      tick();
`ifdef IFETCH_NOP_HALT_EN
      check("nop_count", 32'(bus.nop_count), 32'(i));
`else
      check("nop_count", 32'(bus.nop_count), 32'd0);
      check("nop_halt",  32'(bus.halt),      32'd0);
`endif
    end
`ifdef IFETCH_NOP_HALT_EN
    for (int c = 0; c < 3; c++) begin
      check("halted_halt",  32'(bus.halt),        32'd1);
      check("halted_rd_en", 32'(bus.mem_rd_en),   32'd0);
      check("halted_valid", 32'(bus.instr_valid), 32'd0);
      tick();
    end
`else
    wait_valid();
    check("run_on_pc",    bus.instr_pc, 32'h18);
    check("run_on_instr", bus.instr,    32'h11223344);
    check("run_on_halt",  32'(bus.halt), 32'd0);
    tick();
`endif

    // Redirect back to 0 (leaves HALTED when the feature is built).
    redirect(32'h0);
    check("rd0_halt", 32'(bus.halt),      32'd0);
    check("rd0_nop",  32'(bus.nop_count), 32'd0);
    check("rd0_addr", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h100);
    wait_valid();
    check("rd0_instr", bus.instr,    32'h200a000a);
    check("rd0_pc",    bus.instr_pc, 32'h0);
    tick();

    // Redirect to 0x36 while fetching byte k=2 of the word at 4.
    tick();
    tick();
    check("mid_k2_addr", 32'(bus.mem_addr), 32'h6);
    redirect(32'h36);
    check("mid_addr", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h134);
    wait_valid();
    check("mid_instr", bus.instr,    32'h8d500000);
    check("mid_pc",    bus.instr_pc, 32'h34);
    tick();

    // Address wrap at the top of the 256-byte memory.
    redirect(32'hfc);
    check("wrap_a0", 32'(bus.mem_addr), 32'hfc);
    tick();
    check("wrap_a1", 32'(bus.mem_addr), 32'hfd);
    tick();
    check("wrap_a2", 32'(bus.mem_addr), 32'hfe);
    tick();
    check("wrap_a3", 32'(bus.mem_addr), 32'hff);
    wait_valid();
    check("wrap_instr", bus.instr,    32'haabbccdd);
    check("wrap_pc",    bus.instr_pc, 32'hfc);
    tick();
    check("wrap_next_addr", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h100);
    wait_valid();
    check("wrap_next_pc",    bus.instr_pc, 32'h100);
    check("wrap_next_instr", bus.instr,    32'h200a000a);
    tick();

    // Asynchronous reset in DRAIN of the word at 0x104.
    tick();
    tick();
    tick();
    tick();
    check("pre_rst_drain", 32'(bus.mem_rd_en), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_pc",    bus.instr_pc,         32'h0);
    check("arst_instr", bus.instr,            32'h0);
    check("arst_addr",  {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h0);
    check("arst_halt",  32'(bus.halt),        32'd0);
    check("arst_nop",   32'(bus.nop_count),   32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("refetch_addr", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h100);
    wait_valid();
    check("refetch_pc",    bus.instr_pc, 32'h0);
    check("refetch_instr", bus.instr,    32'h200a000a);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
